// File: rtl/lcd1602_reader.sv
// lcd1602_reader: HD44780 read-cycle bus master (busy-flag/AC and DDRAM/CGRAM reads).
// Busy-flag polling is built in when LCD1602_BUSY_POLL_EN is defined.
module lcd1602_reader #(
    parameter int T_AS     = 2,
    parameter int T_PW     = 10,
    parameter int T_H      = 1,
    parameter int T_REC    = 7,
    parameter int POLL_MAX = 255
) (
    input  logic       lcd_clk_in,
    input  logic       lcd_rst_in,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_busy,
    output logic       rd_timeout,
    input  logic [7:0] LCD_DATA_I,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);
    localparam int M1 = T_AS > T_PW ? T_AS : T_PW;
    localparam int M2 = T_H > T_REC ? T_H : T_REC;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          again;
    logic          again_c;

`ifdef LCD1602_BUSY_POLL_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic          polling;
    logic [PW-1:0] n_reads;
    // another BF read follows only while busy and the poll budget is not spent
    assign again_c = polling && LCD_DATA_I[7] && n_reads != PW'(POLL_MAX - 1);
`else
    logic unused_poll;
    assign again_c     = 1'b0;
    assign rd_timeout  = 1'b0;
    assign unused_poll = req_poll ^ (POLL_MAX == 0);
`endif

    always_ff @(posedge lcd_clk_in) begin
        if (lcd_rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            again     <= 1'b0;
            req_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_busy   <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
            LCD_EN    <= 1'b0;
`ifdef LCD1602_BUSY_POLL_EN
            rd_timeout <= 1'b0;
            polling    <= 1'b0;
            n_reads    <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
`ifdef LCD1602_BUSY_POLL_EN
            rd_timeout <= 1'b0;
`endif
            if (cnt != '0) cnt <= cnt - 1'b1;
            case (state)
                IDLE: if (req_valid) begin
                    state     <= SETUP;
                    cnt       <= CW'(T_AS - 1);
                    LCD_RS    <= req_rs;
                    LCD_RW    <= 1'b1;
                    req_ready <= 1'b0;
                    again     <= 1'b0;
`ifdef LCD1602_BUSY_POLL_EN
                    polling <= req_poll && !req_rs;
                    n_reads <= '0;
`endif
                end
                SETUP: if (cnt == '0) begin
                    state  <= STROBE;
                    cnt    <= CW'(T_PW - 1);
                    LCD_EN <= 1'b1;
                end
                STROBE: if (cnt == '0) begin
                    state   <= HOLD;
                    cnt     <= CW'(T_H - 1);
                    LCD_EN  <= 1'b0;
                    rd_data <= LCD_DATA_I;
                    again   <= again_c;
                    if (!again_c) begin
                        rd_valid <= 1'b1;
                        rd_busy  <= !LCD_RS && LCD_DATA_I[7];
`ifdef LCD1602_BUSY_POLL_EN
                        rd_timeout <= polling && LCD_DATA_I[7];
`endif
                    end
                end
                HOLD: if (cnt == '0) begin
                    state  <= RECOVER;
                    cnt    <= CW'(T_REC - 1);
                    LCD_RW <= 1'b0;
                    LCD_RS <= 1'b0;
                end
                RECOVER: if (cnt == '0) begin
                    if (again) begin
                        state  <= SETUP;
                        cnt    <= CW'(T_AS - 1);
                        LCD_RW <= 1'b1;
`ifdef LCD1602_BUSY_POLL_EN
                        n_reads <= n_reads + 1'b1;
`endif
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd1602_reader.sv
// tb_lcd1602_reader: directed checks of read timing, sampling point, back-to-back and reset abort.
module tb_lcd1602_reader;
    logic       lcd_clk_in = 1'b0;
    logic       lcd_rst_in = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_busy;
    logic       rd_timeout;
    logic [7:0] LCD_DATA_I = 8'h00;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    int checks = 0;
    int errors = 0;

    lcd1602_reader #(.POLL_MAX(4)) dut (
        .lcd_clk_in(lcd_clk_in), .lcd_rst_in(lcd_rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_poll(req_poll),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_busy(rd_busy), .rd_timeout(rd_timeout),
        .LCD_DATA_I(LCD_DATA_I), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    always #5 lcd_clk_in = ~lcd_clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge lcd_clk_in);
    endtask

    // One request; cycle c counts cycles after the accept edge. Data switches to d1 at c=12, d2 at c=13.
    task automatic run_txn(input logic rs, input logic [7:0] d0, d1, d2, input bit pulse,
                           output int first_en, en_cnt, v_cyc, v_cnt, rw_last, rdy, rs_bad,
                           output logic [7:0] dat, output logic bsy);
        first_en = 0; en_cnt = 0; v_cyc = 0; v_cnt = 0; rw_last = 0; rdy = 0; rs_bad = 0;
        dat = 8'hxx; bsy = 1'bx;
        req_rs = rs; LCD_DATA_I = d0; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 12) LCD_DATA_I = d1;
            if (c == 13) LCD_DATA_I = d2;
            if (pulse) req_valid = (c == 5 || c == 16);
            if (LCD_EN && first_en == 0) first_en = c;
            if (LCD_EN) en_cnt++;
            if (rd_valid) begin v_cyc = c; v_cnt++; dat = rd_data; bsy = rd_busy; end
            if (LCD_RW) rw_last = c;
            if (req_ready && rdy == 0) rdy = c;
            if (LCD_RS !== (LCD_RW ? rs : 1'b0)) rs_bad++;
            tick;
        end
        req_valid = 1'b0;
    endtask

`ifdef LCD1602_BUSY_POLL_EN
    task automatic poll_txn(input logic [7:0] fin, input int busy_reads,
                            output int pulses, v_cnt, output logic [7:0] dat, output logic to, bsy);
        logic prev_en;
        pulses = 0; v_cnt = 0; prev_en = 1'b0; dat = 8'hxx; to = 1'bx; bsy = 1'bx;
        req_rs = 1'b0; req_poll = 1'b1; req_valid = 1'b1;
        LCD_DATA_I = busy_reads > 0 ? (fin | 8'h80) : fin;
        tick;
        req_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (prev_en && !LCD_EN) pulses++;
            prev_en = LCD_EN;
            if (rd_valid) begin v_cnt++; dat = rd_data; to = rd_timeout; bsy = rd_busy; end
            LCD_DATA_I = pulses < busy_reads ? (fin | 8'h80) : fin;
            tick;
        end
        req_poll = 1'b0;
    endtask
`endif

    initial begin
        int fe, ec, vc, vn, rl, rd, rb, v1, v2;
        logic [7:0] d;
        logic b;
        tick; tick;
        lcd_rst_in = 1'b0;
        tick;
        chk("rst_ready", req_ready, 1);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_en", LCD_EN, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_timeout", rd_timeout, 0);

        run_txn(1'b0, 8'h8A, 8'h8A, 8'h8A, 1'b0, fe, ec, vc, vn, rl, rd, rb, d, b);
        chk("bf_first_en", fe, 3);
        chk("bf_en_cycles", ec, 10);
        chk("bf_valid_cyc", vc, 13);
        chk("bf_valid_cnt", vn, 1);
        chk("bf_rw_last", rl, 13);
        chk("bf_ready_cyc", rd, 21);
        chk("bf_rs", rb, 0);
        chk("bf_data", d, 8'h8A);
        chk("bf_busy", b, 1);

        run_txn(1'b1, 8'h41, 8'h41, 8'h41, 1'b0, fe, ec, vc, vn, rl, rd, rb, d, b);
        chk("ram_rs", rb, 0);
        chk("ram_data", d, 8'h41);
        chk("ram_busy", b, 0);
        chk("ram_valid_cnt", vn, 1);

        run_txn(1'b1, 8'h00, 8'h55, 8'hAA, 1'b0, fe, ec, vc, vn, rl, rd, rb, d, b);
        chk("late_data", d, 8'h55);
        chk("late_hold", rd_data, 8'h55);
        chk("late_busy_hold", rd_busy, 0);

        run_txn(1'b0, 8'h13, 8'h13, 8'h13, 1'b1, fe, ec, vc, vn, rl, rd, rb, d, b);
        chk("pulse_valid_cnt", vn, 1);
        chk("pulse_ready_cyc", rd, 21);
        chk("pulse_en_cycles", ec, 10);
        chk("pulse_busy", b, 0);

        // requester holds req_valid: accepts every 21 edges, one result each
        vn = 0; v1 = 0; v2 = 0;
        req_rs = 1'b0; LCD_DATA_I = 8'h12; req_valid = 1'b1;
        tick;
        for (int c = 1; c <= 63; c++) begin
            if (rd_valid) begin
                vn++;
                if (v1 == 0) v1 = c; else if (v2 == 0) v2 = c;
            end
            if (c == 63) req_valid = 1'b0;
            tick;
        end
        chk("b2b_valid_cnt", vn, 3);
        chk("b2b_first", v1, 13);
        chk("b2b_second", v2, 34);
        for (int c = 0; c < 25; c++) tick;

        // reset while EN is high
        LCD_DATA_I = 8'h8F; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick;
        chk("abort_en_before", LCD_EN, 1);
        lcd_rst_in = 1'b1;
        tick;
        lcd_rst_in = 1'b0;
        chk("abort_en", LCD_EN, 0);
        chk("abort_rw", LCD_RW, 0);
        chk("abort_ready", req_ready, 1);
        vn = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_valid) vn++;
            tick;
        end
        chk("abort_no_valid", vn, 0);
        chk("abort_idle", req_ready, 1);

`ifdef LCD1602_BUSY_POLL_EN
        poll_txn(8'h05, 3, ec, vn, d, b, b);
        poll_txn(8'h05, 3, ec, vn, d, rl[0], b);
        chk("poll_pulses", ec, 4);
        chk("poll_valid_cnt", vn, 1);
        chk("poll_data", d, 8'h05);
        chk("poll_timeout", rl[0], 0);
        chk("poll_busy", b, 0);
        poll_txn(8'h80, 99, ec, vn, d, rl[0], b);
        chk("stuck_pulses", ec, 4);
        chk("stuck_valid_cnt", vn, 1);
        chk("stuck_timeout", rl[0], 1);
        chk("stuck_busy", b, 1);
`else
        run_txn(1'b0, 8'h80, 8'h80, 8'h80, 1'b0, fe, ec, vc, vn, rl, rd, rb, d, b);
        chk("nopoll_valid_cnt", vn, 1);
        chk("nopoll_timeout", rd_timeout, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
